// File: rtl/rt_pkg.sv
// Shared constants and types for the ray scene scheduler.
// Holds the t encoding, object/ray field widths and the FSM state type.
package rt_pkg;

    localparam int T_W    = 10;
    localparam int OBJ_W  = 56;
    localparam int INIT_W = 28;
    localparam int DIR_W  = 31;

    localparam logic [T_W-1:0] T_MISS = 10'h3FF;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/rt_valid_pipe.sv
// Valid+tag delay line of DEPTH registers; o_* is i_* delayed DEPTH cycles.
// Ports: clk, rst (sync active-low), i_valid/i_tag in, o_valid/o_tag out.
module rt_valid_pipe #(
    parameter int DEPTH = 3,
    parameter int TAG_W = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    output logic [TAG_W-1:0] o_tag
);

    logic [DEPTH-1:0]            r_valid;
    logic [DEPTH-1:0][TAG_W-1:0] r_tag;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid <= '0;
            r_tag   <= '0;
        end else begin
            r_valid[0] <= i_valid;
            r_tag[0]   <= i_tag;
            for (int k = 1; k < DEPTH; k++) begin
                r_valid[k] <= r_valid[k-1];
                r_tag[k]   <= r_tag[k-1];
            end
        end
    end

    assign o_valid = r_valid[DEPTH-1];
    assign o_tag   = r_tag[DEPTH-1];

endmodule

// File: rtl/ray_scene_scheduler.sv
// Walks every scene object for one ray through the box unit, keeps nearest hit.
// Ports: clk/rst, start/ray_init/ray_dir/obj_count in; obj_rd/obj_addr/obj_rdata
// RAM side; box_init/box_dir/box_object/box_t box unit; busy/done/hit/t_min/hit_id.
module ray_scene_scheduler
    import rt_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int MEM_LAT = 1,
    parameter int BOX_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [INIT_W-1:0] ray_init,
    input  logic [DIR_W-1:0]  ray_dir,
    input  logic [ADDR_W:0]   obj_count,
    output logic              obj_rd,
    output logic [ADDR_W-1:0] obj_addr,
    input  logic [OBJ_W-1:0]  obj_rdata,
    output logic [INIT_W-1:0] box_init,
    output logic [DIR_W-1:0]  box_dir,
    output logic [OBJ_W-1:0]  box_object,
    input  logic [T_W-1:0]    box_t,
    output logic              busy,
    output logic              done,
    output logic              hit,
    output logic [T_W-1:0]    t_min,
    output logic [ADDR_W-1:0] hit_id
);

    localparam int DEPTH = MEM_LAT + BOX_LAT;
    localparam int TAG_W = ADDR_W + 1;

    state_t              r_state;
    logic [ADDR_W:0]     r_cnt;
    logic [ADDR_W:0]     r_count;
    logic [INIT_W-1:0]   r_init;
    logic [DIR_W-1:0]    r_dir;
    logic                r_hit;
    logic [T_W-1:0]      r_t_min;
    logic [ADDR_W-1:0]   r_hit_id;

    logic [ADDR_W:0]     w_cnt_nxt;
    logic                w_accept;
    logic                w_p_in_valid;
    logic                w_p_in_last;
    logic [TAG_W-1:0]    w_p_in_tag;
    logic                w_p_valid;
    logic [TAG_W-1:0]    w_p_tag;
    logic                w_p_last;
    logic [ADDR_W-1:0]   w_p_idx;
    logic                w_upd;

    assign w_cnt_nxt    = r_cnt + 1'b1;
    assign w_accept     = (r_state == S_IDLE) && start;
    assign w_p_in_valid = (r_state == S_ISSUE);

    // An end marker rides the pipe behind the last issue (or alone when the
    // scene is empty), so done timing is the same with or without objects.
    assign w_p_in_last  = ((r_state == S_ISSUE) && (w_cnt_nxt == r_count))
                        || (w_accept && (obj_count == '0));
    assign w_p_in_tag   = {w_p_in_last, r_cnt[ADDR_W-1:0]};

    rt_valid_pipe #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) u_pipe (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_p_in_valid),
        .i_tag   (w_p_in_tag),
        .o_valid (w_p_valid),
        .o_tag   (w_p_tag)
    );

    assign w_p_last = w_p_tag[ADDR_W];
    assign w_p_idx  = w_p_tag[ADDR_W-1:0];

    // Strict less-than keeps the lowest index on ties.
    assign w_upd = w_p_valid && (box_t != T_MISS) && (box_t < r_t_min);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_count  <= '0;
            r_init   <= '0;
            r_dir    <= '0;
            r_hit    <= 1'b0;
            r_t_min  <= T_MISS;
            r_hit_id <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_init   <= ray_init;
                        r_dir    <= ray_dir;
                        r_count  <= obj_count;
                        r_cnt    <= '0;
                        r_hit    <= 1'b0;
                        r_t_min  <= T_MISS;
                        r_hit_id <= '0;
                        r_state  <= (obj_count == '0) ? S_DRAIN : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_cnt <= w_cnt_nxt;
                    if (w_cnt_nxt == r_count) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_p_last) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
            if (w_upd) begin
                r_t_min  <= box_t;
                r_hit_id <= w_p_idx;
                r_hit    <= 1'b1;
            end
        end
    end

    assign obj_rd     = (r_state == S_ISSUE);
    assign obj_addr   = r_cnt[ADDR_W-1:0];
    assign box_object = obj_rdata;
    assign box_init   = r_init;
    assign box_dir    = r_dir;
    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_DONE);
    assign hit        = r_hit;
    assign t_min      = r_t_min;
    assign hit_id     = r_hit_id;

endmodule
